// File: rtl/axis_pkt_if.sv
// AXI-Stream channel between the packet master and its downstream slave.
// tready flows back from the slave; everything else flows forward.
interface axis_pkt_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_master.sv
// AXI-Stream packet master: producers fill a FIFO, start drains pkt_len beats onto AXIS.
// Optional AXIS_PKT_OVF_EN adds a sticky ovf flag for writes dropped while the FIFO is full.
module axis_pkt_master #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     start,
    input  logic [LEN_W-1:0]         pkt_len,
    output logic                     busy,
    output logic                     finish,
`ifdef AXIS_PKT_OVF_EN
    output logic                     ovf,
`endif
    axis_pkt_if.master               axis
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;

    logic empty;
    logic hs;
    logic push;
    logic drop;
    logic last_beat;
    logic start_ok;

    // Every AXIS output derives from registers only, so no input reaches them combinationally.
    assign empty       = (count == '0);
    assign full        = (count == FULL_LVL);
    assign level       = count;
    assign busy        = (state == SEND);
    assign axis.tvalid = (state == SEND) && !empty;
    assign axis.tdata  = mem[rd_ptr];
    assign last_beat   = (cnt == len_q - LEN_W'(1));
    assign axis.tlast  = axis.tvalid && last_beat;

    assign hs       = axis.tvalid && axis.tready;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign drop     = wr_en && full && !hs;
    assign push     = wr_en && !drop;
    assign start_ok = (state == IDLE) && start && (pkt_len != '0);

    // NOTE: the storage array has no reset; clearing the pointers and count is what flushes
    // the FIFO, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (hs) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !hs) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (hs && !push) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

    // NOTE: non-blocking assignments throughout, so every decision in this block sees the
    // pre-edge values of the other registers regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            len_q  <= '0;
            cnt    <= '0;
            finish <= 1'b0;
`ifdef AXIS_PKT_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state <= SEND;
                        len_q <= pkt_len;
                        cnt   <= '0;
                    end
                end
                SEND: begin
                    if (hs) begin
                        cnt <= cnt + LEN_W'(1);
                        if (last_beat) begin
                            state  <= IDLE;
                            finish <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef AXIS_PKT_OVF_EN
            // A drop in the same cycle as an accepted start wins: the flag reports the loss.
            if (drop) begin
                ovf <= 1'b1;
            end else if (start_ok) begin
                ovf <= 1'b0;
            end
`endif
        end
    end

endmodule
